// File: rtl/instruction_encoder_pkg.sv
// Shared definitions for the RV32I instruction encoder: format codes, opcode
// constants, immediate range limits, the captured field bundle and FSM states.
package instruction_encoder_pkg;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_S = 2'd2,
        FMT_B = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PACK = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic [6:0] OP_RTYPE  = 7'h33;
    localparam logic [6:0] OP_ITYPE  = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;

    // 12-bit signed immediates (I/S) and 13-bit even byte offsets (B)
    localparam logic signed [31:0] IMM12_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM12_MAX = 32'sd2047;
    localparam logic signed [31:0] IMMB_MIN  = -32'sd4096;
    localparam logic signed [31:0] IMMB_MAX  = 32'sd4094;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    // One accepted field bundle, held while the word is being packed
    typedef struct packed {
        fmt_e        fmt;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
    } fields_t;

    // True when a signed immediate lies outside [lo, hi]
    function automatic logic imm_out_of_range(input logic [31:0] imm,
                                              input logic signed [31:0] lo,
                                              input logic signed [31:0] hi);
        return ($signed(imm) < lo) || ($signed(imm) > hi);
    endfunction

endpackage

// File: rtl/instruction_packer.sv
// Combinational RV32I field packer (R/I/S/B). Immediate range checking is
// compiled in only when ENCODER_RANGE_CHECK_EN is defined; otherwise the
// range error output is constant 0.
module instruction_packer
    import instruction_encoder_pkg::*;
(
    input  fields_t     fields,
    output logic [31:0] word,
    output logic        range_err
);

    // Place each field at its RV32I bit position; unused fields are dropped
    always_comb begin
        word = NOP_WORD;
        case (fields.fmt)
            FMT_R:   word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                             fields.rd, fields.opcode};
            FMT_I:   word = {fields.imm[11:0], fields.rs1, fields.funct3,
                             fields.rd, fields.opcode};
            FMT_S:   word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                             fields.imm[4:0], fields.opcode};
            FMT_B:   word = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                             fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
            default: word = NOP_WORD;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // Flag immediates that do not survive truncation, and odd branch offsets
    always_comb begin
        range_err = 1'b0;
        case (fields.fmt)
            FMT_I, FMT_S: range_err = imm_out_of_range(fields.imm, IMM12_MIN, IMM12_MAX);
            FMT_B:        range_err = imm_out_of_range(fields.imm, IMMB_MIN, IMMB_MAX)
                                      | fields.imm[0];
            default:      range_err = 1'b0;
        endcase
    end
`else
    // Upper immediate bits only matter to the range check
    logic unused_imm_s;
    assign unused_imm_s = ^fields.imm[31:13];

    // No checking in this build
    always_comb begin
        range_err = 1'b0;
    end
`endif

endmodule

// File: rtl/instruction_encoder.sv
// RV32I instruction encoder: accepts a field bundle per valid/ready handshake,
// packs it one cycle later and presents a registered word with a sequential
// word address. Optional immediate range checking: ENCODER_RANGE_CHECK_EN.
module instruction_encoder
    import instruction_encoder_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  validIn,
    output logic                  readyOut,
    input  logic [1:0]            fmtIn,
    input  logic [6:0]            opcodeIn,
    input  logic [4:0]            rdIn,
    input  logic [2:0]            funct3In,
    input  logic [4:0]            rs1In,
    input  logic [4:0]            rs2In,
    input  logic [6:0]            funct7In,
    input  logic [31:0]           immIn,
    output logic                  validOut,
    input  logic                  readyIn,
    output logic [31:0]           instructionOut,
    output logic [ADDR_WIDTH-1:0] addrOut,
    output logic                  errWordOut,
    output logic                  errorOut
);

    state_e                  state_r;
    state_e                  state_next_s;
    fields_t                 fields_r;
    logic [31:0]             packed_word_s;
    logic                    pack_err_s;
    logic                    ready_r;
    logic                    valid_r;
    logic [31:0]             instr_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic                    err_word_r;
    logic                    error_r;
    logic                    accept_s;
    logic                    release_s;

    assign accept_s  = validIn & ready_r;
    assign release_s = valid_r & readyIn;

    instruction_packer u_packer (
        .fields    (fields_r),
        .word      (packed_word_s),
        .range_err (pack_err_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state: accept in IDLE, pack for one cycle, wait for the consumer
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_PACK;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PACK: state_next_s = ST_OUT;
            ST_OUT: begin
                if (release_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs; reset discards any word in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            fields_r   <= {$bits(fields_t){1'b0}};
            ready_r    <= 1'b1;
            valid_r    <= 1'b0;
            instr_r    <= 32'h0000_0000;
            addr_r     <= BASE_ADDR;
            err_word_r <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        fields_r.fmt    <= fmt_e'(fmtIn);
                        fields_r.opcode <= opcodeIn;
                        fields_r.rd     <= rdIn;
                        fields_r.funct3 <= funct3In;
                        fields_r.rs1    <= rs1In;
                        fields_r.rs2    <= rs2In;
                        fields_r.funct7 <= funct7In;
                        fields_r.imm    <= immIn;
                        ready_r         <= 1'b0;
                    end
                end
                ST_PACK: begin
                    instr_r    <= packed_word_s;
                    err_word_r <= pack_err_s;
                    error_r    <= error_r | pack_err_s;
                    valid_r    <= 1'b1;
                end
                ST_OUT: begin
                    if (release_s) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        addr_r  <= addr_r + ADDR_WIDTH'(1'b1);
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign readyOut       = ready_r;
    assign validOut       = valid_r;
    assign instructionOut = instr_r;
    assign addrOut        = addr_r;
    assign errWordOut     = err_word_r;
    assign errorOut       = error_r;

endmodule

// File: tb/tb_instruction_encoder.sv
// Self-checking bench for instruction_encoder: directed RV32I vectors,
// backpressure, randomized bundles against an arithmetic reference model,
// address wrap with a small counter and reset during PACK.
module tb_instruction_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  fmtIn;
    logic [6:0]  opcodeIn;
    logic [4:0]  rdIn, rs1In, rs2In;
    logic [2:0]  funct3In;
    logic [6:0]  funct7In;
    logic [31:0] immIn;

    logic        resetA, validInA, readyInA, readyOutA, validOutA, errWordA, errorA;
    logic [31:0] instrA;
    logic [7:0]  addrA;

    logic        resetB, validInB, readyInB, readyOutB, validOutB, errWordB, errorB;
    logic [31:0] instrB;
    logic [1:0]  addrB;

    instruction_encoder dutA (
        .clk(clk), .reset(resetA), .validIn(validInA), .readyOut(readyOutA),
        .fmtIn(fmtIn), .opcodeIn(opcodeIn), .rdIn(rdIn), .funct3In(funct3In),
        .rs1In(rs1In), .rs2In(rs2In), .funct7In(funct7In), .immIn(immIn),
        .validOut(validOutA), .readyIn(readyInA), .instructionOut(instrA),
        .addrOut(addrA), .errWordOut(errWordA), .errorOut(errorA)
    );

    instruction_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(2'd2)) dutB (
        .clk(clk), .reset(resetB), .validIn(validInB), .readyOut(readyOutB),
        .fmtIn(fmtIn), .opcodeIn(opcodeIn), .rdIn(rdIn), .funct3In(funct3In),
        .rs1In(rs1In), .rs2In(rs2In), .funct7In(funct7In), .immIn(immIn),
        .validOut(validOutB), .readyIn(readyInB), .instructionOut(instrB),
        .addrOut(addrB), .errWordOut(errWordB), .errorOut(errorB)
    );

    int total = 0;
    int bad   = 0;
    int expAddrA = 0;
    logic expSticky = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference packing computed with field weights (powers of two) and modulo arithmetic
    function automatic logic [31:0] refEncode(input logic [31:0] fmt, op, rd, f3,
                                              rs1, rs2, f7, imm);
        logic [31:0] common;
        common = rs1 * 32'd32768 + f3 * 32'd4096 + op;
        case (fmt)
            32'd0:   return f7 * 32'd33554432 + rs2 * 32'd1048576 + common + rd * 32'd128;
            32'd1:   return (imm % 32'd4096) * 32'd1048576 + common + rd * 32'd128;
            32'd2:   return ((imm / 32'd32) % 32'd128) * 32'd33554432 + rs2 * 32'd1048576
                            + common + (imm % 32'd32) * 32'd128;
            default: return ((imm / 32'd4096) % 32'd2) * 32'h8000_0000
                            + ((imm / 32'd32) % 32'd64) * 32'd33554432
                            + rs2 * 32'd1048576 + common
                            + ((imm / 32'd2) % 32'd16) * 32'd256
                            + ((imm / 32'd2048) % 32'd2) * 32'd128;
        endcase
    endfunction

    // Expected per-word range error for the current build
    function automatic logic refErr(input int fmt, input logic [31:0] imm);
`ifdef ENCODER_RANGE_CHECK_EN
        int v;
        v = $signed(imm);
        if (fmt == 1 || fmt == 2) return (v < -2048) || (v > 2047);
        if (fmt == 3) return (v < -4096) || (v > 4094) || (v % 2 != 0);
        return 1'b0;
`else
        return 1'b0 + 1'b0 * imm[0] + 1'b0 * fmt[0];
`endif
    endfunction

    task automatic setFields(input int fmt, op, rd, f3, rs1, rs2, f7, input logic [31:0] imm);
        fmtIn = fmt[1:0]; opcodeIn = op[6:0]; rdIn = rd[4:0]; funct3In = f3[2:0];
        rs1In = rs1[4:0]; rs2In = rs2[4:0]; funct7In = f7[6:0]; immIn = imm;
    endtask

    // One full transaction on dutA with optional consumer stall
    task automatic doTxn(input string name, input int fmt, op, rd, f3, rs1, rs2, f7,
                         input logic [31:0] imm, input logic [31:0] expWord, input int stall);
        logic expErrW;
        setFields(fmt, op, rd, f3, rs1, rs2, f7, imm);
        validInA = 1'b1;
        tick();
        validInA = 1'b0;
        setFields($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom, $urandom,
                  $urandom, $urandom);
        check({name, ".pack.ready"}, readyOutA, 32'd0);
        check({name, ".pack.valid"}, validOutA, 32'd0);
        tick();
        expErrW = refErr(fmt, imm);
        if (expErrW) expSticky = 1'b1;
        check({name, ".valid"}, validOutA, 32'd1);
        check({name, ".word"}, instrA, expWord);
        check({name, ".addr"}, addrA, expAddrA);
        check({name, ".errWord"}, errWordA, expErrW);
        check({name, ".error"}, errorA, expSticky);
        for (int s = 0; s < stall; s++) begin
            readyInA = 1'b0;
            validInA = 1'b1;
            setFields($urandom_range(0, 3), $urandom, $urandom, $urandom, $urandom,
                      $urandom, $urandom, $urandom);
            tick();
            check({name, ".stall.word"}, instrA, expWord);
            check({name, ".stall.addr"}, addrA, expAddrA);
            check({name, ".stall.ready"}, readyOutA, 32'd0);
            check({name, ".stall.valid"}, validOutA, 32'd1);
            check({name, ".stall.errWord"}, errWordA, expErrW);
        end
        readyInA = 1'b1;
        tick();
        validInA = 1'b0;
        readyInA = 1'b0;
        expAddrA = (expAddrA + 1) % 256;
        check({name, ".done.valid"}, validOutA, 32'd0);
        check({name, ".done.ready"}, readyOutA, 32'd1);
        check({name, ".done.addr"}, addrA, expAddrA);
    endtask

    initial begin
        int bounds[9];
        int fmt;
        logic [31:0] imm;
        bounds = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4097};

        resetA = 1'b1; validInA = 1'b0; readyInA = 1'b0;
        resetB = 1'b1; validInB = 1'b0; readyInB = 1'b0;
        setFields(0, 0, 0, 0, 0, 0, 0, 32'd0);
        tick();
        tick();
        resetA = 1'b0;
        resetB = 1'b0;
        check("rst.ready", readyOutA, 32'd1);
        check("rst.valid", validOutA, 32'd0);
        check("rst.word", instrA, 32'd0);
        check("rst.addr", addrA, 32'd0);
        check("rst.errWord", errWordA, 32'd0);
        check("rst.error", errorA, 32'd0);
        check("rstB.addr", addrB, 32'd2);

        // Directed RV32I vectors with known encodings
        doTxn("add", 0, 'h33, 3, 0, 1, 2, 0, 32'd0, 32'h002081B3, 0);
        doTxn("addi", 1, 'h13, 5, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFF00293, 3);
        doTxn("sw", 2, 'h23, 0, 2, 1, 2, 0, 32'd8, 32'h0020A423, 1);
        doTxn("beq", 3, 'h63, 0, 0, 1, 2, 0, 32'hFFFF_FFF8, 32'hFE208CE3, 0);
        // Range boundaries: the word is still emitted with truncated immediate
        doTxn("iover", 1, 'h13, 1, 0, 2, 0, 0, 32'd2048, 32'h80010093, 0);
        doTxn("bodd", 3, 'h63, 0, 0, 1, 2, 0, 32'd3, 32'h00208163, 1);
        doTxn("imax", 1, 'h13, 7, 0, 1, 0, 0, 32'd2047, 32'h7FF08393, 0);

        // Randomized bundles against the reference model
        for (int i = 0; i < 24; i++) begin
            fmt = $urandom_range(0, 3);
            case ($urandom_range(0, 2))
                0:       imm = $urandom_range(0, 8191) - 4096;
                1:       imm = $urandom;
                default: imm = bounds[$urandom_range(0, 8)];
            endcase
            begin
                int op, rd, f3, rs1, rs2, f7;
                op = $urandom_range(0, 127); rd = $urandom_range(0, 31);
                f3 = $urandom_range(0, 7); rs1 = $urandom_range(0, 31);
                rs2 = $urandom_range(0, 31); f7 = $urandom_range(0, 127);
                doTxn($sformatf("rnd%0d", i), fmt, op, rd, f3, rs1, rs2, f7, imm,
                      refEncode(fmt, op, rd, f3, rs1, rs2, f7, imm), $urandom_range(0, 2));
            end
        end

        // Reset clears the sticky error and address
        resetA = 1'b1;
        tick();
        resetA = 1'b0;
        check("rst2.error", errorA, 32'd0);
        check("rst2.addr", addrA, 32'd0);
        check("rst2.valid", validOutA, 32'd0);
        check("rst2.ready", readyOutA, 32'd1);

        // Small counter: back-to-back words wrap 2,3,0,1,2
        validInB = 1'b1;
        readyInB = 1'b1;
        for (int i = 0; i < 5; i++) begin
            setFields(1, 'h13, 1, 0, 0, 0, 0, i);
            tick();
            tick();
            check($sformatf("wrap%0d.valid", i), validOutB, 32'd1);
            check($sformatf("wrap%0d.addr", i), addrB, (2 + i) % 4);
            check($sformatf("wrap%0d.word", i), instrB, refEncode(1, 'h13, 1, 0, 0, 0, 0, i));
            tick();
        end
        readyInB = 1'b0;
        // validInB still high: this edge accepts the next bundle into PACK
        tick();
        validInB = 1'b0;
        check("midrst.pack.ready", readyOutB, 32'd0);
        resetB = 1'b1;
        tick();
        resetB = 1'b0;
        check("midrst.valid", validOutB, 32'd0);
        check("midrst.addr", addrB, 32'd2);
        check("midrst.ready", readyOutB, 32'd1);
        tick();
        check("midrst.valid2", validOutB, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
Name: instruction_encoder

Overview:
- Packs RV32I instruction fields (R/I/S/B formats) into 32-bit instruction words. It is the inverse of the core's field decoder.
- Sits between a test or program source and instruction memory. Accepts one field bundle per valid/ready handshake and emits a registered word plus a sequential memory write address.
- Intended use: program loading and self-check of the decode path.

Parameters:
- ADDR_WIDTH, 8, width of write-address counter (word addresses).
- BASE_ADDR, 0, address assigned to the first word after reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- validIn  input  1  field bundle valid
- readyOut  output  1  encoder can accept a bundle
- fmtIn  input  2  format: 0=R, 1=I, 2=S, 3=B
- opcodeIn  input  7  opcode, passed through to bits [6:0]
- rdIn  input  5  destination register (R/I only)
- funct3In  input  3  funct3
- rs1In  input  5  source 1
- rs2In  input  5  source 2 (R/S/B only)
- funct7In  input  7  funct7 (R only)
- immIn  input  32  signed immediate; B format is a byte offset
- validOut  output  1  encoded word valid
- readyIn  input  1  consumer accepts word
- instructionOut  output  32  encoded instruction
- addrOut  output  ADDR_WIDTH  word address for instructionOut
- errWordOut  output  1  current word had an immediate range error (qualified by validOut)
- errorOut  output  1  sticky error flag

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, port reset.
- Reset values:
  - FSM goes to IDLE.
  - readyOut=1, validOut=0, instructionOut=0, addrOut=BASE_ADDR, errWordOut=0, errorOut=0.
- FSM states: IDLE, PACK, OUT.
  - IDLE: readyOut=1. When validIn&readyOut at edge N, capture all fields and go to PACK.
  - PACK: readyOut=0. At edge N+1, register instructionOut and errWordOut, then go to OUT. validOut is high from edge N+1.
  - OUT: validOut=1, and instructionOut, addrOut and errWordOut are held stable. On validOut&readyIn at edge M: addrOut increments, state goes to IDLE, validOut=0, and readyOut=1 after edge M.
- Timing: latency is 1 cycle from acceptance to validOut. Throughput is at most one word per 3 cycles. validIn is ignored outside IDLE.
- Packing:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - Fields unused by a format are ignored. Immediate bits above the format width are truncated.
- Address counter: increments modulo 2^ADDR_WIDTH. The all-ones address is followed by 0, not by BASE_ADDR.
- Reset mid-operation (PACK or OUT): the word is discarded, validOut drops next cycle, and addrOut returns to BASE_ADDR.
- errorOut: set at the PACK->OUT transition when errWordOut is set. Cleared only by reset.

Optional Feature:
- Macro: ENCODER_RANGE_CHECK_EN.
- Defined:
  - errWordOut=1 if an I/S immediate is outside [-2048, 2047].
  - errWordOut=1 if a B immediate is outside [-4096, 4094] or has bit0=1.
  - The word is still emitted with the truncated immediate, and errorOut is set.
- Undefined: no checks; errWordOut and errorOut are tied to 0.

Decomposition:
- Shared package holds:
  - format codes (FMT_R, FMT_I, FMT_S, FMT_B)
  - opcode constants (OP_RTYPE 0x33, OP_ITYPE 0x13, OP_LOAD 0x03, OP_STORE 0x23, OP_BRANCH 0x63)
  - immediate range limits
  - NOP word 0x00000013
- One combinational sub-module, instruction_packer: fields plus format in, 32-bit word and range error out.
- The FSM, counter and handshake stay in instruction_encoder.

Test Plan:
- R add x3,x1,x2: fmt=0, op=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> instructionOut=0x002081B3, addrOut=0.
- I addi x5,x0,-1: fmt=1, op=0x13, rd=5, imm=0xFFFFFFFF -> 0xFFF00293. S sw x2,8(x1): fmt=2, op=0x23, f3=2, rs1=1, rs2=2, imm=8 -> 0x0020A423.
- B beq x1,x2,-8: fmt=3, op=0x63, f3=0, rs1=1, rs2=2, imm=-8 -> 0xFE208CE3.
- Backpressure: hold readyIn=0 for 3 cycles in OUT -> word and addrOut stable, readyOut=0, validIn ignored. readyIn=1 -> addrOut+1, readyOut=1 next cycle.
- With ENCODER_RANGE_CHECK_EN:
  - I imm=2048 -> errWordOut=1, errorOut stays 1 afterwards.
  - A following B imm=3 -> errWordOut=1.
  - reset -> errorOut=0.
- ADDR_WIDTH=2, BASE_ADDR=2: five back-to-back words -> addrOut 2, 3, 0, 1, 2. Reset asserted in PACK -> validOut stays 0, addrOut=2.
